wptr_full: RTL and testbench

Write-side pointer and full-flag logic of the dual-clock asynchronous FIFO, running entirely in the write clock domain. It accepts write requests, advances a binary/Gray write pointer pair, and synchronizes the Gray read pointer into `wclk`. It generates registered full, almost-full, fill-count and sticky overflow status. It drives the dual-port memory write address and exports the Gray write pointer for synchronization into the read domain.

---
 rtl/fifo_pkg.sv | 32 +++
 rtl/sync_r2w.sv | 34 +++
 rtl/wptr_full.sv | 91 +++++++++
 tb/tb_wptr_full.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Shared constants and Gray/binary helpers for the async FIFO.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

    localparam int c_ADDRSIZE = 6;

    // Operands are zero-extended to 32 bits; the result is masked to width bits.
    function automatic logic [31:0] width_mask(input int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned width);
        return (b ^ (b >> 1)) & width_mask(width);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned width);
        logic [31:0] v_g;
        logic [31:0] v_b;
        v_g = g & width_mask(width);
        v_b = v_g;
        for (int i = 1; i < 32; i++) begin
            v_b = v_b ^ (v_g >> i);
        end
        return v_b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_r2w.sv
`default_nettype none
// ============================================================================
//  Module   : sync_r2w
//  Purpose  : Two-flop synchronizer bringing the Gray read pointer into wclk.
//  Revision : 1.0  initial release
// ============================================================================
module sync_r2w
    import fifo_pkg::*;
#(
    parameter int WIDTH = c_ADDRSIZE + 1
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic [WIDTH-1:0] rptr,
    output logic [WIDTH-1:0] wq2_rptr
);

    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_q2;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= rptr;
            r_q2 <= r_q1;
        end
    end

    assign wq2_rptr = r_q2;

endmodule
`default_nettype wire

// File: rtl/wptr_full.sv
`default_nettype none
// ============================================================================
//  Module   : wptr_full
//  Purpose  : Write pointer, full/almost-full, fill count and overflow status
//             for the write domain of the asynchronous FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = c_ADDRSIZE,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wcount,
    output logic                woverflow
);

    localparam int                c_PW       = ADDRSIZE + 1;
    localparam logic [c_PW-1:0]   c_AFULL_TH = c_PW'((2 ** ADDRSIZE) - AFULL_MARGIN);

    logic [c_PW-1:0] r_wbin;
    logic [c_PW-1:0] r_wptr;
    logic            r_wfull;
    logic            r_wafull;
    logic [c_PW-1:0] r_wcount;
    logic            r_woverflow;

    logic [c_PW-1:0] w_wq2_rptr;
    logic [c_PW-1:0] w_rbin_s;
    logic            w_wen;
    logic [c_PW-1:0] w_wbinnext;
    logic [c_PW-1:0] w_wgraynext;
    logic [c_PW-1:0] w_wcount_val;
    logic            w_wfull_val;
    logic            w_wafull_val;

    sync_r2w #(
        .WIDTH    (c_PW)
    ) u_sync_r2w (
        .wclk     (wclk),
        .wrst     (wrst),
        .rptr     (rptr),
        .wq2_rptr (w_wq2_rptr)
    );

    assign w_wen        = winc & ~r_wfull;
    assign w_wbinnext   = r_wbin + c_PW'(w_wen);
    assign w_wgraynext  = c_PW'(bin2gray(32'(w_wbinnext), c_PW));
    assign w_rbin_s     = c_PW'(gray2bin(32'(w_wq2_rptr), c_PW));
    assign w_wcount_val = w_wbinnext - w_rbin_s;

    // Full when the next write pointer is exactly one lap ahead of the read pointer.
    assign w_wfull_val  = (w_wgraynext == {~w_wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                           w_wq2_rptr[ADDRSIZE-2:0]});
    assign w_wafull_val = (w_wcount_val >= c_AFULL_TH);

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_wbin      <= '0;
            r_wptr      <= '0;
            r_wfull     <= 1'b0;
            r_wafull    <= 1'b0;
            r_wcount    <= '0;
            r_woverflow <= 1'b0;
        end else begin
            r_wbin      <= w_wbinnext;
            r_wptr      <= w_wgraynext;
            r_wfull     <= w_wfull_val;
            r_wafull    <= w_wafull_val;
            r_wcount    <= w_wcount_val;
            r_woverflow <= r_woverflow | (winc & r_wfull);
        end
    end

    assign waddr     = r_wbin[ADDRSIZE-1:0];
    assign wptr      = r_wptr;
    assign wfull     = r_wfull;
    assign wafull    = r_wafull;
    assign wcount    = r_wcount;
    assign woverflow = r_woverflow;

endmodule
`default_nettype wire

// File: tb/tb_wptr_full.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wptr_full
//  Purpose  : Self-checking bench for wptr_full with a counting reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wptr_full;

    localparam int c_A = 6;

    logic         wclk;
    logic         wrst;
    logic         winc;
    logic [c_A:0] rptr;
    logic [c_A-1:0] waddr;
    logic [c_A:0] wptr;
    logic         wfull;
    logic         wafull;
    logic [c_A:0] wcount;
    logic         woverflow;

    int n_pass  = 0;
    int n_total = 0;

    wptr_full #(
        .ADDRSIZE     (c_A),
        .AFULL_MARGIN (4)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .winc      (winc),
        .rptr      (rptr),
        .waddr     (waddr),
        .wptr      (wptr),
        .wfull     (wfull),
        .wafull    (wafull),
        .wcount    (wcount),
        .woverflow (woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & 127;
    endfunction

    function automatic int from_gray(input int g);
        int b;
        b = 0;
        for (int i = 6; i >= 0; i--) begin
            b = b | ((((b >> (i + 1)) & 1) ^ ((g >> i) & 1)) << i);
        end
        return b;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference model: counts writes and tracks the read pointer seen two edges late.
    int m_wr_tot = 0;
    int m_cnt    = 0;
    bit m_full   = 0;
    bit m_afull  = 0;
    bit m_ovf    = 0;
    int m_s1     = 0;
    int m_s2     = 0;
    bit m_valid  = 0;

    always @(posedge wclk) begin
        bit wen;
        int rd_seen;
        if (wrst) begin
            m_wr_tot = 0; m_cnt = 0; m_full = 0; m_afull = 0; m_ovf = 0;
            m_s1 = 0; m_s2 = 0; m_valid = 1;
        end else begin
            wen = winc && !m_full;
            if (winc && m_full) m_ovf = 1;
            if (wen) m_wr_tot++;
            rd_seen = from_gray(m_s2);
            m_cnt   = (m_wr_tot - rd_seen) & 127;
            m_full  = (m_cnt == 64);
            m_afull = (m_cnt >= 60);
            m_s2    = m_s1;
            m_s1    = int'(rptr);
        end
        #1;
        if (m_valid) begin
            chk("model_wptr",   int'(wptr),      to_gray(m_wr_tot & 127));
            chk("model_waddr",  int'(waddr),     m_wr_tot & 63);
            chk("model_wcount", int'(wcount),    m_cnt);
            chk("model_wfull",  int'(wfull),     int'(m_full));
            chk("model_wafull", int'(wafull),    int'(m_afull));
            chk("model_wovf",   int'(woverflow), int'(m_ovf));
        end
    end

    // Inputs change on the falling edge; the DUT samples them on the rising edge.
    task automatic cyc(input bit inc);
        winc = inc;
        @(posedge wclk);
        @(negedge wclk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_wptr"},   int'(wptr),      0);
        chk({nm, "_waddr"},  int'(waddr),     0);
        chk({nm, "_wcount"}, int'(wcount),    0);
        chk({nm, "_wfull"},  int'(wfull),     0);
        chk({nm, "_wafull"}, int'(wafull),    0);
        chk({nm, "_wovf"},   int'(woverflow), 0);
    endtask

    int rd_tot;

    task automatic do_reset();
        wrst   = 1'b1;
        rptr   = '0;
        rd_tot = 0;
        cyc(1'b1);
        wrst   = 1'b0;
    endtask

    initial begin
        int max_cnt;
        bit full_seen;
        wrst = 1'b1; winc = 1'b1; rptr = '0; rd_tot = 0;

        // Reset held two cycles with a write request pending
        @(negedge wclk);
        cyc(1'b1);
        cyc(1'b1);
        chk_zero("reset");
        wrst = 1'b0;

        // Fill with the read pointer parked at zero
        for (int i = 1; i <= 64; i++) begin
            cyc(1'b1);
            if (i == 59) chk("fill_wafull_59", int'(wafull), 0);
            if (i == 60) begin
                chk("fill_wafull_60", int'(wafull), 1);
                chk("fill_wcount_60", int'(wcount), 60);
            end
        end
        chk("fill_wfull",  int'(wfull),  1);
        chk("fill_wcount", int'(wcount), 64);
        chk("fill_wptr",   int'(wptr),   7'b1100000);
        chk("fill_waddr",  int'(waddr),  0);

        // Writes while full are refused and flagged
        for (int i = 0; i < 3; i++) cyc(1'b1);
        chk("ovf_wptr",   int'(wptr),      7'b1100000);
        chk("ovf_waddr",  int'(waddr),     0);
        chk("ovf_wcount", int'(wcount),    64);
        chk("ovf_flag",   int'(woverflow), 1);
        cyc(1'b0);
        chk("ovf_sticky", int'(woverflow), 1);

        // One read drains a slot three edges later
        rptr = 7'b0000001;
        rd_tot = 1;
        cyc(1'b0);
        chk("drain_e1_wfull", int'(wfull), 1);
        cyc(1'b0);
        chk("drain_e2_wfull", int'(wfull), 1);
        cyc(1'b0);
        chk("drain_e3_wfull",  int'(wfull),  0);
        chk("drain_e3_wcount", int'(wcount), 63);
        chk("drain_e3_wafull", int'(wafull), 1);

        // Continuous write with the read pointer trailing closely, across the wrap
        do_reset();
        max_cnt = 0;
        full_seen = 0;
        for (int i = 1; i <= 300; i++) begin
            rptr = 7'(to_gray(m_wr_tot & 127));
            cyc(1'b1);
            if (int'(wcount) > max_cnt) max_cnt = int'(wcount);
            if (wfull) full_seen = 1;
            if (i == 127) chk("wrap_wptr_127", int'(wptr), 7'b1000000);
            if (i == 128) chk("wrap_wptr_128", int'(wptr), 7'b0000000);
        end
        chk("wrap_full_seen", int'(full_seen), 0);
        chk("wrap_max_le3",   int'(max_cnt <= 3), 1);

        // Randomized writes and reads in alternating slow/fast read phases
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int rate;
            rate = ((i / 100) % 2 == 1) ? 75 : 12;
            if (rd_tot < m_wr_tot && $urandom_range(99) < rate) rd_tot++;
            rptr = 7'(to_gray(rd_tot & 127));
            cyc(1'($urandom_range(99) < 70));
        end

        // Reset in the middle of operation
        do_reset();
        for (int i = 0; i < 40; i++) cyc(1'b1);
        chk("mid_wcount_40", int'(wcount), 40);
        wrst = 1'b1;
        cyc(1'b1);
        chk_zero("midrst");
        wrst = 1'b0;
        cyc(1'b1);
        chk("midrst_waddr_after",  int'(waddr),  1);
        chk("midrst_wcount_after", int'(wcount), 1);
        chk("midrst_wptr_after",   int'(wptr),   1);

        cyc(1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
